// File: rtl/stft_framer_pkg.sv
// Shared types and arithmetic helpers for the STFT framer.
// Holds the FSM state type, window-select codes, ring-pointer wrap and fixed-point rounding.
package stft_framer_pkg;

   typedef enum logic [1:0] {StIdle, StEmit, StDrain} state_e;

   localparam logic WIN_RECT = 1'b0;
   localparam logic WIN_HANN = 1'b1;

   // Modular add; callers guarantee inc <= depth.
   function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned inc,
                                            input int unsigned depth);
      int unsigned sum;
      sum = ptr + inc;
      return (sum >= depth) ? sum - depth : sum;
   endfunction

   // Round-half-up of p / 2**(coe_w-1), clamped to the signed data_w-bit range.
   function automatic longint sat_round(input longint p, input int unsigned coe_w,
                                        input int unsigned data_w);
      longint r;
      longint hi;
      longint lo;
      r  = (p + (longint'(1) <<< (coe_w - 2))) >>> (coe_w - 1);
      hi = (longint'(1) <<< (data_w - 1)) - 1;
      lo = -(longint'(1) <<< (data_w - 1));
      if (r > hi) begin
         r = hi;
      end else if (r < lo) begin
         r = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/stft_framer_win_coe_rom.sv
// Window coefficient ROM with a registered read: constant 1.0 for rectangular,
// periodic Hann table (built at elaboration) otherwise; indices past the window read 0.
module win_coe_rom
   import stft_framer_pkg::*;
#(
   parameter int unsigned COE_WIDTH = 16,
   parameter int unsigned WIN_LEN   = 480,
   parameter int unsigned AW        = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic                 win_sel_i,
   input  logic [AW-1:0]        addr_i,
   output logic [COE_WIDTH-1:0] coe_o
);

   localparam int unsigned ONE = 1 << (COE_WIDTH - 1);
   localparam int unsigned RW  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

   logic [COE_WIDTH-1:0] hann_tbl [WIN_LEN];
   logic [COE_WIDTH-1:0] coe_d;
   logic [COE_WIDTH-1:0] coe_q;

   for (genvar n = 0; n < WIN_LEN; n++) begin : g_hann
      localparam real ANG = 2.0 * 3.14159265358979323846 * real'(n) / real'(WIN_LEN);
      localparam int unsigned VAL = $rtoi(real'(ONE) * 0.5 * (1.0 - $cos(ANG)) + 0.5);
      assign hann_tbl[n] = COE_WIDTH'(VAL);
   end

   always_comb begin
      coe_d = '0;
      unique case (win_sel_i)
         WIN_RECT: coe_d = COE_WIDTH'(ONE);
         WIN_HANN: begin
            if (32'(addr_i) < WIN_LEN) begin
               coe_d = hann_tbl[RW'(addr_i)];
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coe_q <= '0;
      end else if (en_i) begin
         coe_q <= coe_d;
      end
   end

   assign coe_o = coe_q;

endmodule

// File: rtl/stft_framer.sv
// Streaming STFT front end: ring-buffers samples, emits overlapping windowed frames
// zero-padded to N_FFT beats through a 2-stage (read, multiply) valid/ready pipeline.
module stft_framer
   import stft_framer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned COE_WIDTH  = 16,
   parameter int unsigned N_FFT      = 512,
   parameter int unsigned WIN_LEN    = 480,
   parameter int unsigned HOP_LEN    = 160,
   parameter int unsigned BUF_DEPTH  = WIN_LEN + HOP_LEN,
   parameter int unsigned FCNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  win_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_sof,
   output logic                  out_last,
   output logic [FCNT_WIDTH-1:0] frame_cnt
);

   localparam int unsigned PW     = $clog2(BUF_DEPTH);
   localparam int unsigned FW     = $clog2(BUF_DEPTH + 1);
   localparam int unsigned IW     = $clog2(N_FFT + 1);
   localparam int unsigned PROD_W = DATA_WIDTH + COE_WIDTH + 1;

   state_e state_q, state_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         base_q, base_d;
   logic [FW-1:0]         fill_q, fill_d;
   logic [IW-1:0]         rd_idx_q, rd_idx_d;
   logic                  win_sel_q, win_sel_d;
   logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

   logic s1_valid_q, s1_valid_d;
   logic s1_sof_q, s1_sof_d;
   logic s1_last_q, s1_last_d;
   logic s1_zero_q, s1_zero_d;

   logic                  out_valid_q, out_valid_d;
   logic                  out_sof_q, out_sof_d;
   logic                  out_last_q, out_last_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic [DATA_WIDTH-1:0] ring_mem [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] ram_rdata_q;
   logic [PW-1:0]         rd_addr;
   logic [COE_WIDTH-1:0]  coe;

   logic                  advance, wr_en, issue, rd_in_win, rd_en, last_idx, drain_done;
   logic signed [PROD_W-1:0] prod;
   logic [DATA_WIDTH-1:0]    s2_data;

   assign in_ready  = 32'(fill_q) < BUF_DEPTH;
   assign wr_en     = in_valid && in_ready;
   assign advance   = !out_valid_q || out_ready;
   assign issue     = (state_q == StEmit) && advance;
   assign rd_in_win = 32'(rd_idx_q) < WIN_LEN;
   assign rd_en     = issue && rd_in_win;
   assign last_idx  = rd_idx_q == IW'(N_FFT - 1);
   assign rd_addr   = PW'(ptr_wrap(32'(base_q), 32'(rd_idx_q), BUF_DEPTH));

   // Simple dual-port RAM; the read register holds while the pipe is stalled.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ring_mem[wr_ptr_q] <= in_data;
      end
      if (rd_en) begin
         ram_rdata_q <= ring_mem[rd_addr];
      end
   end

   win_coe_rom #(
      .COE_WIDTH (COE_WIDTH),
      .WIN_LEN   (WIN_LEN),
      .AW        (IW)
   ) u_win_coe_rom (
      .clk       (clk),
      .rst       (rst),
      .en_i      (issue),
      .win_sel_i (win_sel_q),
      .addr_i    (rd_idx_q),
      .coe_o     (coe)
   );

   always_comb begin
      prod    = PROD_W'($signed(ram_rdata_q)) * PROD_W'($signed({1'b0, coe}));
      s2_data = DATA_WIDTH'(sat_round(longint'(prod), COE_WIDTH, DATA_WIDTH));
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      base_d      = base_q;
      rd_idx_d    = rd_idx_q;
      win_sel_d   = win_sel_q;
      frame_cnt_d = frame_cnt_q;
      s1_valid_d  = s1_valid_q;
      s1_sof_d    = s1_sof_q;
      s1_last_d   = s1_last_q;
      s1_zero_d   = s1_zero_q;
      out_valid_d = out_valid_q;
      out_sof_d   = out_sof_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      drain_done  = 1'b0;

      if (wr_en) begin
         wr_ptr_d = PW'(ptr_wrap(32'(wr_ptr_q), 1, BUF_DEPTH));
      end

      unique case (state_q)
         StIdle: begin
            if (32'(fill_q) >= WIN_LEN) begin
               state_d   = StEmit;
               win_sel_d = win_sel;
               rd_idx_d  = '0;
            end
         end
         StEmit: begin
            if (advance) begin
               rd_idx_d = rd_idx_q + IW'(1);
               if (last_idx) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (out_valid_q && out_ready && out_last_q) begin
               drain_done  = 1'b1;
               base_d      = PW'(ptr_wrap(32'(base_q), HOP_LEN, BUF_DEPTH));
               frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1);
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      fill_d = fill_q + FW'(wr_en) - (drain_done ? FW'(HOP_LEN) : FW'(0));

      if (advance) begin
         s1_valid_d  = issue;
         s1_sof_d    = issue && (rd_idx_q == '0);
         s1_last_d   = issue && last_idx;
         s1_zero_d   = !rd_in_win;
         out_valid_d = s1_valid_q;
         out_sof_d   = s1_sof_q;
         out_last_d  = s1_last_q;
         out_data_d  = (s1_valid_q && !s1_zero_q) ? s2_data : '0;
      end

      // Flush abandons the frame in flight and discards any same-cycle write.
      if (flush) begin
         state_d     = StIdle;
         wr_ptr_d    = '0;
         base_d      = '0;
         fill_d      = '0;
         rd_idx_d    = '0;
         frame_cnt_d = frame_cnt_q;
         s1_valid_d  = 1'b0;
         s1_sof_d    = 1'b0;
         s1_last_d   = 1'b0;
         out_valid_d = 1'b0;
         out_sof_d   = 1'b0;
         out_last_d  = 1'b0;
         out_data_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         base_q      <= '0;
         fill_q      <= '0;
         rd_idx_q    <= '0;
         win_sel_q   <= 1'b0;
         frame_cnt_q <= '0;
         s1_valid_q  <= 1'b0;
         s1_sof_q    <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_zero_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         base_q      <= base_d;
         fill_q      <= fill_d;
         rd_idx_q    <= rd_idx_d;
         win_sel_q   <= win_sel_d;
         frame_cnt_q <= frame_cnt_d;
         s1_valid_q  <= s1_valid_d;
         s1_sof_q    <= s1_sof_d;
         s1_last_q   <= s1_last_d;
         s1_zero_q   <= s1_zero_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_stft_framer.sv
// Directed bench for stft_framer in the small configuration (N_FFT=8, WIN_LEN=6, HOP_LEN=2).
module tb_stft_framer;

   localparam int unsigned DW = 16;
   localparam int unsigned FW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          win_sel = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_sof;
   logic          out_last;
   logic [FW-1:0] frame_cnt;

   int n_pass = 0;
   int n_total = 0;

   int src_q[$];
   int got_data[$];
   bit got_sof[$];
   bit got_last[$];
   int got_fc[$];
   int accepted;
   int stall_bad;
   int timeout;
   int acc_at_hold;
   bit rdy_at_hold;

   always #5 clk = ~clk;

   stft_framer #(
      .DATA_WIDTH (16),
      .COE_WIDTH  (16),
      .N_FFT      (8),
      .WIN_LEN    (6),
      .HOP_LEN    (2),
      .BUF_DEPTH  (8),
      .FCNT_WIDTH (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .win_sel   (win_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sof   (out_sof),
      .out_last  (out_last),
      .frame_cnt (frame_cnt)
   );

   task automatic apply_reset();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      win_sel = 1'b0;
      in_data = '0;
      src_q.delete();
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Streams src_q in and records accepted beats; mode 0 ready=1, 1 random, 2 low until hold.
   task automatic collect(input int n_beats, input int mode, input int hold, input int budget);
      int cyc;
      bit pend;
      bit prev_stall;
      logic [DW-1:0] prev_data;
      int dummy;
      cyc = 0;
      pend = 0;
      prev_stall = 0;
      prev_data = '0;
      got_data.delete();
      got_sof.delete();
      got_last.delete();
      got_fc.delete();
      accepted = 0;
      stall_bad = 0;
      timeout = 0;
      while (got_data.size() < n_beats || pend) begin
         if (cyc >= budget) begin
            timeout = 1;
            break;
         end
         in_valid = (src_q.size() > 0);
         in_data = in_valid ? DW'(src_q[0]) : '0;
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (cyc >= hold);
         endcase
         @(negedge clk);
         if (cyc == hold) begin
            acc_at_hold = accepted;
            rdy_at_hold = in_ready;
         end
         if (pend) begin
            got_fc.push_back(int'(frame_cnt));
            pend = 0;
         end
         if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
         prev_stall = out_valid && !out_ready;
         prev_data = out_data;
         if (in_valid && in_ready) begin
            dummy = src_q.pop_front();
            accepted++;
         end
         if (out_valid && out_ready) begin
            got_data.push_back(int'($signed(out_data)));
            got_sof.push_back(out_sof);
            got_last.push_back(out_last);
            if (out_last) pend = 1;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %0b expected 0", out_valid);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %0b expected 1", in_ready);
      else n_pass++;
      n_total++;
      if (out_data !== '0 || out_sof !== 1'b0 || out_last !== 1'b0)
         $display("FAIL reset outputs: got data=%0h sof=%0b last=%0b expected 0 0 0",
                  out_data, out_sof, out_last);
      else n_pass++;
      n_total++;
      if (frame_cnt !== '0) $display("FAIL reset frame_cnt: got %0d expected 0", frame_cnt);
      else n_pass++;
   endtask

   task automatic test_ramp();
      int f;
      int k;
      int e;
      apply_reset();
      for (int i = 1; i <= 10; i++) src_q.push_back(i);
      collect(24, 0, 0, 500);
      n_total++;
      if (timeout !== 0) $display("FAIL ramp timeout: got %0d beats expected 24", got_data.size());
      else n_pass++;
      for (int i = 0; i < 24; i++) begin
         f = i / 8;
         k = i % 8;
         e = (k < 6) ? 1 + 2 * f + k : 0;
         n_total++;
         if (i >= got_data.size() || got_data[i] !== e || got_sof[i] !== (k == 0) ||
             got_last[i] !== (k == 7))
            $display("FAIL ramp beat %0d: got data=%0d sof=%0b last=%0b expected %0d %0b %0b",
                     i, got_data[i], got_sof[i], got_last[i], e, k == 0, k == 7);
         else n_pass++;
      end
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (i >= got_fc.size() || got_fc[i] !== i + 1)
            $display("FAIL ramp frame_cnt %0d: got %0d expected %0d", i, got_fc[i], i + 1);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int f;
      int k;
      int e;
      apply_reset();
      for (int i = 1; i <= 10; i++) src_q.push_back(i);
      collect(24, 2, 30, 600);
      n_total++;
      if (timeout !== 0) $display("FAIL bp timeout: got %0d beats expected 24", got_data.size());
      else n_pass++;
      n_total++;
      if (acc_at_hold !== 8) $display("FAIL bp accepted while stalled: got %0d expected 8",
                                      acc_at_hold);
      else n_pass++;
      n_total++;
      if (rdy_at_hold !== 1'b0) $display("FAIL bp in_ready when full: got %0b expected 0",
                                         rdy_at_hold);
      else n_pass++;
      n_total++;
      if (accepted !== 10) $display("FAIL bp total accepted: got %0d expected 10", accepted);
      else n_pass++;
      for (int i = 0; i < 24; i++) begin
         f = i / 8;
         k = i % 8;
         e = (k < 6) ? 1 + 2 * f + k : 0;
         n_total++;
         if (i >= got_data.size() || got_data[i] !== e || got_sof[i] !== (k == 0) ||
             got_last[i] !== (k == 7))
            $display("FAIL bp beat %0d: got data=%0d sof=%0b last=%0b expected %0d %0b %0b",
                     i, got_data[i], got_sof[i], got_last[i], e, k == 0, k == 7);
         else n_pass++;
      end
   endtask

   task automatic test_random_ready();
      int f;
      int k;
      int e;
      apply_reset();
      for (int i = 1; i <= 10; i++) src_q.push_back(i);
      collect(24, 1, 0, 1000);
      n_total++;
      if (timeout !== 0) $display("FAIL rand timeout: got %0d beats expected 24", got_data.size());
      else n_pass++;
      n_total++;
      if (stall_bad !== 0) $display("FAIL rand stall stability: got %0d changes expected 0",
                                    stall_bad);
      else n_pass++;
      for (int i = 0; i < 24; i++) begin
         f = i / 8;
         k = i % 8;
         e = (k < 6) ? 1 + 2 * f + k : 0;
         n_total++;
         if (i >= got_data.size() || got_data[i] !== e || got_sof[i] !== (k == 0) ||
             got_last[i] !== (k == 7))
            $display("FAIL rand beat %0d: got data=%0d sof=%0b last=%0b expected %0d %0b %0b",
                     i, got_data[i], got_sof[i], got_last[i], e, k == 0, k == 7);
         else n_pass++;
      end
      n_total++;
      if (got_fc.size() < 3 || got_fc[2] !== 3)
         $display("FAIL rand frame_cnt: got %0d expected 3", frame_cnt);
      else n_pass++;
   endtask

   task automatic test_hann();
      int exp_h[8] = '{0, 8192, 24575, 32767, 24575, 8192, 0, 0};
      apply_reset();
      win_sel = 1'b1;
      for (int i = 0; i < 6; i++) src_q.push_back(32767);
      collect(8, 0, 0, 200);
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if (i >= got_data.size() || got_data[i] !== exp_h[i])
            $display("FAIL hann beat %0d: got %0d expected %0d", i, got_data[i], exp_h[i]);
         else n_pass++;
      end
   endtask

   task automatic test_neg_full();
      int exp_h[8] = '{0, -8192, -24576, -32768, -24576, -8192, 0, 0};
      int e;
      apply_reset();
      win_sel = 1'b0;
      for (int i = 0; i < 6; i++) src_q.push_back(-32768);
      collect(8, 0, 0, 200);
      for (int i = 0; i < 8; i++) begin
         e = (i < 6) ? -32768 : 0;
         n_total++;
         if (i >= got_data.size() || got_data[i] !== e)
            $display("FAIL neg rect beat %0d: got %0d expected %0d", i, got_data[i], e);
         else n_pass++;
      end
      apply_reset();
      win_sel = 1'b1;
      for (int i = 0; i < 6; i++) src_q.push_back(-32768);
      collect(8, 0, 0, 200);
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if (i >= got_data.size() || got_data[i] !== exp_h[i])
            $display("FAIL neg hann beat %0d: got %0d expected %0d", i, got_data[i], exp_h[i]);
         else n_pass++;
      end
   endtask

   task automatic test_flush();
      int idle_valid;
      int e;
      apply_reset();
      for (int i = 1; i <= 8; i++) src_q.push_back(i);
      collect(12, 0, 0, 300);
      n_total++;
      if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd7)
         $display("FAIL flush pre beat4: got valid=%0b data=%0d expected 1 7",
                  out_valid, $signed(out_data));
      else n_pass++;
      flush = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL flush out_valid: got %0b expected 0", out_valid);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL flush in_ready: got %0b expected 1", in_ready);
      else n_pass++;
      n_total++;
      if (frame_cnt !== 16'd1) $display("FAIL flush frame_cnt: got %0d expected 1", frame_cnt);
      else n_pass++;
      idle_valid = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) idle_valid++;
      end
      @(posedge clk);
      #1;
      n_total++;
      if (idle_valid !== 0) $display("FAIL flush idle beats: got %0d expected 0", idle_valid);
      else n_pass++;
      for (int i = 101; i <= 106; i++) src_q.push_back(i);
      collect(8, 0, 0, 200);
      for (int i = 0; i < 8; i++) begin
         e = (i < 6) ? 101 + i : 0;
         n_total++;
         if (i >= got_data.size() || got_data[i] !== e || got_sof[i] !== (i == 0))
            $display("FAIL flush next beat %0d: got data=%0d sof=%0b expected %0d %0b",
                     i, got_data[i], got_sof[i], e, i == 0);
         else n_pass++;
      end
      n_total++;
      if (frame_cnt !== 16'd2) $display("FAIL flush next frame_cnt: got %0d expected 2", frame_cnt);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 1; i <= 8; i++) src_q.push_back(i);
      collect(10, 0, 0, 200);
      out_ready = 1'b1;
      n_total++;
      if (out_valid !== 1'b1 || frame_cnt !== 16'd1)
         $display("FAIL arst pre state: got valid=%0b cnt=%0d expected 1 1", out_valid, frame_cnt);
      else n_pass++;
      #3 rst = 1'b1;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_sof !== 1'b0 ||
          out_last !== 1'b0 || frame_cnt !== '0)
         $display("FAIL arst state: got valid=%0b rdy=%0b data=%0h sof=%0b last=%0b cnt=%0d expected 0 1 0 0 0 0",
                  out_valid, in_ready, out_data, out_sof, out_last, frame_cnt);
      else n_pass++;
      @(posedge clk);
      #3 rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_backpressure();
      test_random_ready();
      test_hann();
      test_neg_full();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
